// File: rtl/adc_serial_rx.sv
// adc_serial_rx: serial front end for ADC7476-style converters.
// Drives CS / SCLK, skips LEAD_BITS leading bits and shifts DATA_W bits
// MSB-first from CHANNELS parallel data lines that share CS and SCLK.
// Each completed frame is presented on a valid/ready port. Sticky overrun
// flags a frame that replaced one the consumer had not yet taken.

// Per-channel shift register: one instance per converter data line.
module adc_serial_rx_lane #(
  parameter int DATA_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              shift_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] word_o
);

  logic [DATA_W-1:0] word_q, word_d;

  // New bits enter at the LSB, so the first kept bit ends up as the MSB
  always_comb begin
    word_d = word_q;
    if (shift_i) word_d = {word_q[DATA_W-2:0], bit_i};
  end

  // Shift register state; reset discards any partial frame
  always_ff @(posedge clk_i) begin
    if (rst_i) word_q <= '0;
    else       word_q <= word_d;
  end

  assign word_o = word_q;

endmodule

module adc_serial_rx #(
  parameter int DATA_W    = 12,
  parameter int LEAD_BITS = 4,
  parameter int CHANNELS  = 1,
  parameter int CLK_DIV   = 4,
  parameter int QUIET_CYC = 2
) (
  input  logic                         clock_In,
  input  logic                         Reset,
  input  logic                         start,
  input  logic [CHANNELS-1:0]          data_ADC,
  output logic                         CS,
  output logic                         Clock_Muestreo,
  output logic [CHANNELS*DATA_W-1:0]   sample_data,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic                         done,
  output logic                         busy,
  output logic                         overrun
);

  // Captures per frame (leading + data bits) and quiet gap length in clocks
  localparam int TOTAL = LEAD_BITS + DATA_W;
  localparam int QLEN  = 2 * CLK_DIV * QUIET_CYC;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(TOTAL + 1);
  localparam int Q_W   = $clog2(QLEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CONV  = 2'd1;
  localparam logic [1:0] S_QUIET = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [BIT_W-1:0] bit_q,   bit_d;
  logic [Q_W-1:0]   qcnt_q,  qcnt_d;
  logic             cs_q,    cs_d;
  logic             sclk_q,  sclk_d;
  logic             valid_q, valid_d;
  logic             done_q,  done_d;
  logic             ovr_q,   ovr_d;
  logic [CHANNELS-1:0][DATA_W-1:0] data_q, data_d;
  logic [CHANNELS-1:0][DATA_W-1:0] lane_word;

  logic shift_en;
  logic load;

  // One shift register per converter line, all stepped by the shared capture strobe
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    adc_serial_rx_lane #(.DATA_W(DATA_W)) u_lane (
      .clk_i   (clock_In),
      .rst_i   (Reset),
      .shift_i (shift_en),
      .bit_i   (data_ADC[g]),
      .word_o  (lane_word[g])
    );
  end

  // Sequencer: CS/SCLK generation, capture strobes, frame completion and quiet gap.
  // bit_q counts SCLK rising edges; reaching TOTAL means the last capture has
  // happened and the following edge publishes the frame.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    qcnt_d   = qcnt_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    shift_en = 1'b0;
    load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CONV;
          cs_d    = 1'b0;
          sclk_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_CONV: begin
        if (bit_q == BIT_W'(TOTAL)) begin
          load    = 1'b1;
          state_d = S_QUIET;
          cs_d    = 1'b1;
          sclk_d  = 1'b1;
          div_d   = '0;
          qcnt_d  = '0;
        end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // SCLK going 0->1: sample every line, drop the leading bits
          if (!sclk_q) begin
            bit_d    = bit_q + BIT_W'(1);
            shift_en = (bit_q >= BIT_W'(LEAD_BITS));
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_QUIET: begin
        if (qcnt_q == Q_W'(QLEN - 1)) begin
          qcnt_d = '0;
          if (start) begin
            state_d = S_CONV;
            cs_d    = 1'b0;
            sclk_d  = 1'b1;
            div_d   = '0;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          qcnt_d = qcnt_q + Q_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
  end

  // Output port: a new frame always wins over a same-cycle transfer and keeps
  // valid high; replacing an untaken frame raises the sticky overrun flag
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    if (load) begin
      data_d  = lane_word;
      valid_d = 1'b1;
      done_d  = 1'b1;
      if (valid_q && !sample_ready) ovr_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset abandons any frame in progress
  always_ff @(posedge clock_In) begin
    if (Reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      qcnt_q  <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      qcnt_q  <= qcnt_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign CS             = cs_q;
  assign Clock_Muestreo = sclk_q;
  assign sample_data    = data_q;
  assign sample_valid   = valid_q;
  assign done           = done_q;
  assign busy           = (state_q != S_IDLE);
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: default instance checked every cycle against a
// timeline model, plus a 2-channel / CLK_DIV=2 instance checked by literals.
`timescale 1ns/1ps
module tb_adc_serial_rx;

  localparam int DIV   = 4;
  localparam int F_CYC = 2 * DIV * 16;  // entry edge to last capture
  localparam int Q_CYC = 16;            // quiet gap in clocks

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        rst_a, start_a, ready_a;
  logic [0:0]  din_a;
  logic        cs_a, sclk_a, valid_a, done_a, busy_a, ovr_a;
  logic [11:0] data_a;
  // two-channel instance
  logic        rst_b, start_b, ready_b;
  logic [1:0]  din_b;
  logic        cs_b, sclk_b, valid_b, done_b, busy_b, ovr_b;
  logic [23:0] data_b;

  adc_serial_rx u_dut_a (
    .clock_In(clk), .Reset(rst_a), .start(start_a), .data_ADC(din_a),
    .CS(cs_a), .Clock_Muestreo(sclk_a), .sample_data(data_a),
    .sample_valid(valid_a), .sample_ready(ready_a), .done(done_a),
    .busy(busy_a), .overrun(ovr_a)
  );

  adc_serial_rx #(.CHANNELS(2), .CLK_DIV(2)) u_dut_b (
    .clock_In(clk), .Reset(rst_b), .start(start_b), .data_ADC(din_b),
    .CS(cs_b), .Clock_Muestreo(sclk_b), .sample_data(data_b),
    .sample_valid(valid_b), .sample_ready(ready_b), .done(done_b),
    .busy(busy_b), .overrun(ovr_b)
  );

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Converter model A: new word latched on CS fall, one bit out per SCLK fall
  logic [11:0] adc_q[$];
  logic [15:0] adc_fr = '0;
  int          adc_idx = 0;
  always @(negedge cs_a) begin
    adc_fr = 16'h0;
    if (adc_q.size() > 0) adc_fr[11:0] = adc_q.pop_front();
    adc_idx = 0;
  end
  always @(negedge sclk_a) begin
    if (cs_a === 1'b0 && adc_idx < 16) begin
      din_a[0] = adc_fr[15-adc_idx];
      adc_idx++;
    end
  end

  // Converter model B: fixed words 0x123 / 0xFED on lines 0 / 1
  logic [15:0] frb0 = 16'h0123;
  logic [15:0] frb1 = 16'h0FED;
  int          idx_b = 0;
  always @(negedge cs_b) idx_b = 0;
  always @(negedge sclk_b) begin
    if (cs_b === 1'b0 && idx_b < 16) begin
      din_b = {frb1[15-idx_b], frb0[15-idx_b]};
      idx_b++;
    end
  end

  // Timeline model of instance A: a frame keeps CS low for F_CYC+1 clocks,
  // SCLK is high/low in alternating runs of DIV clocks starting high, the
  // frame is published on the clock after the last capture, then Q_CYC clocks
  // of gap follow before start is looked at again.
  logic [11:0] mdl_q[$];
  int          m_st = 0;  // 0 idle, 1 frame, 2 gap
  int          m_t = 0, m_g = 0;
  logic [11:0] m_word = '0, m_data = '0;
  logic        m_valid = 1'b0, m_done = 1'b0, m_ovr = 1'b0;

  always @(posedge clk) begin
    bit ld;
    ld = 1'b0;
    if (rst_a) begin
      m_st = 0; m_t = 0; m_g = 0;
      m_data = '0; m_valid = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_st)
        0: if (start_a) begin
             m_st = 1; m_t = 0;
             m_word = '0;
             if (mdl_q.size() > 0) m_word = mdl_q.pop_front();
           end
        1: if (m_t == F_CYC) begin ld = 1'b1; m_st = 2; m_g = 0; end
           else m_t++;
        default:
           if (m_g == Q_CYC - 1) begin
             if (start_a) begin
               m_st = 1; m_t = 0;
               m_word = '0;
               if (mdl_q.size() > 0) m_word = mdl_q.pop_front();
             end else m_st = 0;
           end else m_g++;
      endcase
      if (ld) begin
        if (m_valid && !ready_a) m_ovr = 1'b1;
        m_data = m_word; m_valid = 1'b1; m_done = 1'b1;
      end else if (m_valid && ready_a) m_valid = 1'b0;
    end
  end

  // Per-cycle compare of instance A against the model
  always @(negedge clk) begin
    logic exp_sclk;
    if (chk_en) begin
      exp_sclk = (m_st == 1) ? (((m_t / DIV) % 2) == 0) : 1'b1;
      chk("m_cs",    cs_a,    (m_st != 1));
      chk("m_sclk",  sclk_a,  exp_sclk);
      chk("m_busy",  busy_a,  (m_st != 0));
      chk("m_done",  done_a,  m_done);
      chk("m_valid", valid_a, m_valid);
      chk("m_ovr",   ovr_a,   m_ovr);
      chk("m_data",  data_a,  m_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [11:0] w);
    adc_q.push_back(w);
    mdl_q.push_back(w);
  endtask

  // Bounded wait: sel 0 = CS low, 1 = done high, 2 = busy low
  task automatic wait_a(input string nm, input int sel, input int lim);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if ((sel == 0 && cs_a === 1'b0) || (sel == 1 && done_a === 1'b1) ||
          (sel == 2 && busy_a === 1'b0)) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(nm, hit, 1);
  endtask

  // Called on the first negedge with CS low; counts CS-low clocks and the
  // clock offset (from CS fall) at which done is seen
  task automatic meas_a(output int low, output int dn, output logic [11:0] d);
    low = 0; dn = -1; d = '0;
    for (int i = 0; i < 400; i++) begin
      if (done_a === 1'b1 && dn < 0) begin dn = i; d = data_a; end
      if (cs_a !== 1'b0) break;
      low++;
      @(negedge clk);
    end
  endtask

  task automatic gap_a(output int g);
    g = 0;
    for (int i = 0; i < 100 && cs_a === 1'b1; i++) begin
      g++;
      @(negedge clk);
    end
  endtask

  initial begin
    int low, dn, g, k, rises;
    logic [11:0] d;
    logic [23:0] db;
    logic prev;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b0; ready_b = 1'b1; din_a = '0; din_b = '0;

    // T1 reset
    tick(3);
    chk("t1_cs", cs_a, 1);      chk("t1_sclk", sclk_a, 1);
    chk("t1_valid", valid_a, 0); chk("t1_done", done_a, 0);
    chk("t1_busy", busy_a, 0);  chk("t1_ovr", ovr_a, 0);
    chk("t1_b_cs", cs_b, 1);    chk("t1_b_valid", valid_b, 0);
    rst_a = 1'b0; rst_b = 1'b0; chk_en = 1'b1;

    // T2 single frame: CS low from the entry edge through the publishing edge
    push_word(12'hA5C);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    wait_a("t2_cs_fall", 0, 10);
    meas_a(low, dn, d);
    chk("t2_cs_low", low, 129);
    chk("t2_done_at", dn, 129);
    chk("t2_data", d, 12'hA5C);
    tick(20);
    chk("t2_idle", busy_a, 0);
    chk("t2_valid_held", valid_a, 1);

    // T3 continuous conversion with ready high
    ready_a = 1'b1;
    push_word(12'h000); push_word(12'hFFF); push_word(12'h800);
    start_a = 1'b1;
    wait_a("t3_f1", 0, 10);
    meas_a(low, dn, d);
    chk("t3_f1_low", low, 129); chk("t3_f1_data", d, 12'h000);
    gap_a(g); chk("t3_gap1", g, 16);
    meas_a(low, dn, d);
    chk("t3_f2_done_at", dn, 129); chk("t3_f2_data", d, 12'hFFF);
    gap_a(g); chk("t3_gap2", g, 16);
    tick(60); start_a = 1'b0;
    wait_a("t3_f3_done", 1, 200);
    chk("t3_f3_data", data_a, 12'h800);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); k++;
      if (busy_a === 1'b0) break;
    end
    chk("t3_busy_fall", k, 16);
    chk("t3_ovr", ovr_a, 0);

    // T4 overrun with ready low across two frames
    ready_a = 1'b0;
    push_word(12'h111); push_word(12'h222);
    start_a = 1'b1;
    wait_a("t4_done1", 1, 200);
    chk("t4_data1", data_a, 12'h111); chk("t4_ovr1", ovr_a, 0);
    wait_a("t4_f2", 0, 40);
    start_a = 1'b0;
    wait_a("t4_done2", 1, 200);
    chk("t4_data2", data_a, 12'h222);
    chk("t4_ovr2", ovr_a, 1);
    chk("t4_valid2", valid_a, 1);
    tick(3); ready_a = 1'b1; tick(1);
    chk("t4_taken", valid_a, 0);
    chk("t4_ovr_sticky", ovr_a, 1);

    // T6 reset after the 6th SCLK rise, then a clean frame
    wait_a("t6_idle", 2, 40);
    push_word(12'h3C3); push_word(12'h5A5);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    wait_a("t6_cs_fall", 0, 10);
    rises = 0; prev = sclk_a;
    for (int i = 0; i < 200 && rises < 6; i++) begin
      @(negedge clk);
      if (!prev && sclk_a) rises++;
      prev = sclk_a;
    end
    chk("t6_rises", rises, 6);
    rst_a = 1'b1; tick(1);
    chk("t6_cs", cs_a, 1); chk("t6_sclk", sclk_a, 1);
    chk("t6_valid", valid_a, 0); chk("t6_busy", busy_a, 0);
    rst_a = 1'b0; tick(2);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    wait_a("t6_cs_fall2", 0, 10);
    wait_a("t6_done", 1, 200);
    chk("t6_data", data_a, 12'h5A5);
    chk("t6_ovr", ovr_a, 0);

    // T5 two channels, CLK_DIV=2: 2*2*16 clocks to last capture, +1 to publish
    start_b = 1'b1; tick(1); start_b = 1'b0;
    k = 0;
    for (int i = 0; i < 10 && cs_b !== 1'b0; i++) begin @(negedge clk); k++; end
    chk("t5_cs_fall", cs_b, 0);
    low = 0; dn = -1; db = '0;
    for (int i = 0; i < 200; i++) begin
      if (done_b === 1'b1 && dn < 0) begin dn = i; db = data_b; end
      if (cs_b !== 1'b0) break;
      low++;
      @(negedge clk);
    end
    chk("t5_cs_low", low, 65);
    chk("t5_done_at", dn, 65);
    chk("t5_data", db, 24'hFED123);
    tick(20);
    chk("t5_idle", busy_b, 0);
    chk("t5_ovr", ovr_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
